board_debug_display: RTL and testbench

- Parametrised successor to the board-level debug I/O for the 32-bit CPU board.
- Multiplexes N seven-segment digits over one of several selectable 32-bit debug channels (PC, regfile read port, dmem word, ...), shown one window of nibbles at a time.
- Also debounces the single-step button into a one-cycle CPU step pulse.
- Sits between the CPU core's debug taps and the board pins, replacing the fixed 4-digit scan logic.

---
 rtl/board_debug_display.sv | 178 +++++++++++++++++
 tb/tb_board_debug_display.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/board_debug_display.sv
// Multiplexed seven-segment debug display with windowed channel view and step-button debouncer.
// Optional macro LEADING_ZERO_BLANK_EN blanks leading zero digits of the shown window.
module board_debug_display #(
    parameter int DATA_W     = 32,
    parameter int CHANNELS   = 4,
    parameter int DIGITS     = 4,
    parameter int SCAN_DIV   = 50000,
    parameter int DEB_CYCLES = 20000,
    parameter int WIN_W      = 1,
    parameter int SEL_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                       sys_clk,
    input  logic                       scan_rst,
    input  logic [CHANNELS*DATA_W-1:0] ch_data,
    input  logic [SEL_W-1:0]           ch_sel,
    input  logic [WIN_W-1:0]           win_sel,
    input  logic                       button_clk,
    output logic [6:0]                 Y_r,
    output logic [DIGITS-1:0]          DIG_r,
    output logic                       step_pulse
);

    localparam int CNT_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int DEB_W  = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int WORD_W = 4 * DIGITS;
    localparam int NWIN   = DATA_W / WORD_W;

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              active_q, active_d;
    logic [DATA_W-1:0] snap_q, snap_d;
    logic [WIN_W-1:0]  win_q, win_d;
    logic              valid_q, valid_d;
    logic [6:0]        y_q, y_d;
    logic [DIGITS-1:0] dig_q, dig_d;

    logic              sync1_q, sync1_d;
    logic              sync2_q, sync2_d;
    logic              deb_q, deb_d;
    logic              deb_prev_q, deb_prev_d;
    logic [DEB_W-1:0]  dcnt_q, dcnt_d;
    logic              pulse_q, pulse_d;

    logic [DATA_W-1:0] sel_word;
    logic              sel_ok;
    logic              tick;
    logic [WORD_W-1:0] win_word;
    logic [WORD_W-1:0] upper;

    function automatic logic [6:0] seg7(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    function automatic logic [WORD_W-1:0] window_of(
        input logic [DATA_W-1:0] s,
        input logic [WIN_W-1:0]  w,
        input logic              v
    );
        logic [DATA_W-1:0] sh;
        sh = s >> (WORD_W * int'(w));
        if (!v || int'(w) >= NWIN) return '0;
        return sh[WORD_W-1:0];
    endfunction

    always_comb begin
        sel_word = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (int'(ch_sel) == k) sel_word = ch_data[k*DATA_W +: DATA_W];
        end
        sel_ok = int'(ch_sel) < CHANNELS;
    end

    // Outputs are computed from the post-tick index and snapshot
    always_comb begin
        tick     = (cnt_q == CNT_W'(SCAN_DIV - 1));
        cnt_d    = tick ? '0 : cnt_q + CNT_W'(1);
        idx_d    = idx_q;
        active_d = active_q;
        snap_d   = snap_q;
        win_d    = win_q;
        valid_d  = valid_q;
        y_d      = y_q;
        dig_d    = dig_q;
        win_word = '0;
        upper    = '0;
        if (tick) begin
            active_d = 1'b1;
            if (!active_q || idx_q == IDX_W'(DIGITS - 1)) idx_d = '0;
            else idx_d = idx_q + IDX_W'(1);
            if (idx_d == '0) begin
                snap_d  = sel_word;
                win_d   = win_sel;
                valid_d = sel_ok;
            end
            win_word = window_of(snap_d, win_d, valid_d);
            upper    = win_word >> (4 * int'(idx_d));
`ifdef LEADING_ZERO_BLANK_EN
            if (upper == '0 && idx_d != '0) y_d = 7'h7F;
            else y_d = seg7(upper[3:0]);
`else
            y_d = seg7(upper[3:0]);
`endif
            dig_d = ~(DIGITS'(1) << idx_d);
        end
    end

    always_comb begin
        sync1_d    = button_clk;
        sync2_d    = sync1_q;
        deb_d      = deb_q;
        dcnt_d     = '0;
        if (sync2_q != deb_q) begin
            if (dcnt_q == DEB_W'(DEB_CYCLES - 1)) deb_d = ~deb_q;
            else dcnt_d = dcnt_q + DEB_W'(1);
        end
        deb_prev_d = deb_q;
        pulse_d    = deb_q & ~deb_prev_q;
    end

    always_ff @(posedge sys_clk or posedge scan_rst) begin
        if (scan_rst) begin
            cnt_q      <= '0;
            idx_q      <= '0;
            active_q   <= 1'b0;
            snap_q     <= '0;
            win_q      <= '0;
            valid_q    <= 1'b0;
            y_q        <= 7'h7F;
            dig_q      <= '1;
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            deb_q      <= 1'b0;
            deb_prev_q <= 1'b0;
            dcnt_q     <= '0;
            pulse_q    <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            active_q   <= active_d;
            snap_q     <= snap_d;
            win_q      <= win_d;
            valid_q    <= valid_d;
            y_q        <= y_d;
            dig_q      <= dig_d;
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            deb_q      <= deb_d;
            deb_prev_q <= deb_prev_d;
            dcnt_q     <= dcnt_d;
            pulse_q    <= pulse_d;
        end
    end

    assign Y_r        = y_q;
    assign DIG_r      = dig_q;
    assign step_pulse = pulse_q;

endmodule

// File: tb/tb_board_debug_display.sv
// Directed bench for board_debug_display: scan frames via a scoreboard queue, debounce timing.
module tb_board_debug_display;

    logic        sys_clk;
    logic        scan_rst;
    logic [95:0] ch_data;
    logic [1:0]  ch_sel;
    logic [0:0]  win_sel;
    logic        button_clk;
    logic [6:0]  Y_r;
    logic [3:0]  DIG_r;
    logic        step_pulse;

    int n_cmp = 0;
    int n_err = 0;

    logic [10:0] exp_q[$];
    string       tag_q[$];

`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [6:0] LZ = 7'h7F;
`else
    localparam logic [6:0] LZ = 7'h40;
`endif

    board_debug_display #(
        .DATA_W(32), .CHANNELS(3), .DIGITS(4),
        .SCAN_DIV(4), .DEB_CYCLES(8), .WIN_W(1)
    ) dut (
        .sys_clk(sys_clk), .scan_rst(scan_rst), .ch_data(ch_data),
        .ch_sel(ch_sel), .win_sel(win_sel), .button_clk(button_clk),
        .Y_r(Y_r), .DIG_r(DIG_r), .step_pulse(step_pulse)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_frame(input string f, input logic [6:0] y0, input logic [6:0] y1,
                              input logic [6:0] y2, input logic [6:0] y3);
        exp_q.push_back({4'hE, y0}); tag_q.push_back({f, "_d0"});
        exp_q.push_back({4'hD, y1}); tag_q.push_back({f, "_d1"});
        exp_q.push_back({4'hB, y2}); tag_q.push_back({f, "_d2"});
        exp_q.push_back({4'h7, y3}); tag_q.push_back({f, "_d3"});
    endtask

    task automatic check_next();
        logic [10:0] base, cur, exp;
        string tag;
        bit seen;
        base = {DIG_r, Y_r};
        cur  = base;
        seen = 1'b0;
        for (int n = 0; n < 8 && !seen; n++) begin
            @(posedge sys_clk); #1;
            cur = {DIG_r, Y_r};
            if (cur != base) seen = 1'b1;
        end
        exp = exp_q.pop_front();
        tag = tag_q.pop_front();
        check({tag, "_tick"}, 32'(seen), 32'd1);
        check(tag, 32'(cur), 32'(exp));
    endtask

    task automatic watch(input int cycles, output int npulse, output int first);
        npulse = 0;
        first  = -1;
        for (int n = 0; n < cycles; n++) begin
            @(posedge sys_clk); #1;
            if (step_pulse) begin
                npulse++;
                if (first < 0) first = n;
            end
        end
    endtask

    initial begin
        int np, fp, np2, fp2, dfirst;
        scan_rst   = 1'b1;
        button_clk = 1'b0;
        ch_sel     = 2'd0;
        win_sel    = 1'b0;
        ch_data    = {32'h00C00F70, 32'h00000005, 32'h1234ABCD};
        repeat (3) @(posedge sys_clk);
        #1;
        check("rst_y", 32'(Y_r), 32'h7F);
        check("rst_dig", 32'(DIG_r), 32'hF);
        check("rst_pulse", 32'(step_pulse), 32'd0);
        @(negedge sys_clk);
        scan_rst = 1'b0;

        push_frame("f1_ch0_w0", 7'h21, 7'h46, 7'h03, 7'h08);
        check_next();
        win_sel = 1'b1;
        repeat (3) check_next();

        push_frame("f2_ch0_w1", 7'h19, 7'h30, 7'h24, 7'h79);
        check_next();
        win_sel = 1'b0;
        repeat (3) check_next();

        push_frame("f3_coherent", 7'h21, 7'h46, 7'h03, 7'h08);
        repeat (3) check_next();
        ch_sel = 2'd1;
        check_next();

        push_frame("f4_ch1", 7'h12, LZ, LZ, LZ);
        check_next();
        ch_sel = 2'd3;
        repeat (3) check_next();

        push_frame("f5_invalid", 7'h40, LZ, LZ, LZ);
        check_next();
        ch_sel = 2'd2;
        repeat (3) check_next();

        push_frame("f6_ch2_w0", 7'h40, 7'h78, 7'h0E, LZ);
        check_next();
        win_sel = 1'b1;
        repeat (3) check_next();

        push_frame("f7_ch2_w1", 7'h40, 7'h46, LZ, LZ);
        repeat (4) check_next();

        @(negedge sys_clk);
        button_clk = 1'b1;
        watch(30, np, fp);
        check("hold_count", 32'(np), 32'd1);
        check("hold_latency", 32'(fp), 32'd10);
        button_clk = 1'b0;
        watch(20, np, fp);
        check("release_none", 32'(np), 32'd0);

        @(negedge sys_clk);
        button_clk = 1'b1;
        watch(5, np, fp);
        button_clk = 1'b0;
        watch(20, np2, fp2);
        check("glitch_none", 32'(np + np2), 32'd0);

        @(negedge sys_clk);
        np2 = 0;
        for (int t = 0; t < 3; t++) begin
            button_clk = 1'b1;
            watch(2, np, fp);
            np2 += np;
            button_clk = 1'b0;
            watch(2, np, fp);
            np2 += np;
        end
        check("bounce_none", 32'(np2), 32'd0);
        button_clk = 1'b1;
        watch(30, np, fp);
        check("bounce_count", 32'(np), 32'd1);
        check("bounce_latency", 32'(fp), 32'd10);
        button_clk = 1'b0;
        watch(20, np, fp);
        check("bounce_release", 32'(np), 32'd0);

        @(negedge sys_clk);
        button_clk = 1'b1;
        watch(7, np, fp);
        check("pre_rst_none", 32'(np), 32'd0);
        #2;
        scan_rst = 1'b1;
        #1;
        check("async_rst_y", 32'(Y_r), 32'h7F);
        check("async_rst_dig", 32'(DIG_r), 32'hF);
        check("async_rst_pulse", 32'(step_pulse), 32'd0);
        @(negedge sys_clk);
        @(negedge sys_clk);
        scan_rst = 1'b0;
        np     = 0;
        fp     = -1;
        dfirst = -1;
        for (int n = 0; n < 30; n++) begin
            @(posedge sys_clk); #1;
            if (DIG_r != 4'hF && dfirst < 0) dfirst = n;
            if (step_pulse) begin
                np++;
                if (fp < 0) fp = n;
            end
        end
        check("post_rst_first_digit", 32'(dfirst), 32'd3);
        check("post_rst_pulse_count", 32'(np), 32'd1);
        check("post_rst_pulse_latency", 32'(fp), 32'd10);
        button_clk = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
